// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: MIPS memory opcodes,
// LSU FSM states and opcode classification helpers.
package pipe_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } access_size_t;

    function automatic logic is_load(input logic [5:0] opc);
        logic r;
        case (opc)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: r = 1'b1;
            default:                                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [5:0] opc);
        logic r;
        case (opc)
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic access_size_t access_size(input logic [5:0] opc);
        access_size_t r;
        case (opc)
            OP_LB, OP_LBU, OP_SB:               r = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH:               r = SZ_HALF;
            OP_LW, OP_LWL, OP_LWR, OP_SW:       r = SZ_WORD;
            default:                            r = SZ_NONE;
        endcase
        return r;
    endfunction

    // LWL/LWR exist precisely to handle unaligned words, so they never fault.
    function automatic logic is_misaligned(input logic [5:0] opc, input logic [1:0] b);
        logic r;
        case (access_size(opc))
            SZ_HALF: r = b[0];
            SZ_WORD: r = (opc != OP_LWL) && (opc != OP_LWR) && (b != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_lane_steer.sv
// Combinational byte-lane steering: byte enables, replicated store data and
// load extract / sign-extend / LWL-LWR merge for a DATA_W-bit little-endian bus.
module pipe_lane_steer
    import pipe_mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic [5:0]        opcode,
    input  logic [LANE_W-1:0] addr_lo,
    input  logic [31:0]       rt,
    input  logic [DATA_W-1:0] rdata,
    output logic [LANES-1:0]  byteenable,
    output logic [DATA_W-1:0] writedata,
    output logic [31:0]       load_data
);

    logic [1:0]        b;
    logic [LANE_W-1:0] w_lane;
    logic [3:0]        lwl_lanes;
    logic [3:0]        lwr_lanes;
    logic [15:0]       half_raw;
    logic [31:0]       word;
    logic              misal;
    access_size_t      size;

    assign b      = addr_lo[1:0];
    assign w_lane = addr_lo - LANE_W'(b);

    always_comb begin
        size      = access_size(opcode);
        misal     = is_misaligned(opcode, b);
        lwl_lanes = 4'hF >> (2'd3 - b);
        lwr_lanes = 4'hF << b;
        half_raw  = 16'(rdata >> {addr_lo, 3'b000});
        word      = 32'(rdata >> {w_lane, 3'b000});

        byteenable = '0;
        writedata  = {(LANES / 4){rt}};
        case (size)
            SZ_BYTE: begin
                byteenable = LANES'(1) << addr_lo;
                writedata  = {LANES{rt[7:0]}};
            end
            SZ_HALF: begin
                byteenable = LANES'(2'b11) << addr_lo;
                writedata  = {(LANES / 2){rt[15:0]}};
            end
            SZ_WORD: begin
                if (opcode == OP_LWL)      byteenable = LANES'(lwl_lanes) << w_lane;
                else if (opcode == OP_LWR) byteenable = LANES'(lwr_lanes) << w_lane;
                else                       byteenable = LANES'(4'hF) << w_lane;
            end
            default: byteenable = '0;
        endcase
        if (misal) byteenable = '0;

        // LWL: (word << 8*(3-b)) | low rt bytes; LWR: (word >> 8*b) | high rt bytes.
        load_data = 32'h0;
        case (opcode)
            OP_LB:  load_data = {{24{half_raw[7]}}, half_raw[7:0]};
            OP_LBU: load_data = {24'h0, half_raw[7:0]};
            OP_LH:  load_data = {{16{half_raw[15]}}, half_raw};
            OP_LHU: load_data = {16'h0, half_raw};
            OP_LW:  load_data = word;
            OP_LWL: begin
                case (b)
                    2'd0:    load_data = {word[7:0],  rt[23:0]};
                    2'd1:    load_data = {word[15:0], rt[15:0]};
                    2'd2:    load_data = {word[23:0], rt[7:0]};
                    default: load_data = word;
                endcase
            end
            OP_LWR: begin
                case (b)
                    2'd0:    load_data = word;
                    2'd1:    load_data = {rt[31:24], word[31:8]};
                    2'd2:    load_data = {rt[31:16], word[31:16]};
                    default: load_data = {rt[31:8],  word[31:24]};
                endcase
            end
            default: load_data = 32'h0;
        endcase
        if (misal) load_data = 32'h0;
    end

endmodule

// File: rtl/pipe_lsu_aligned_access.sv
// MEM-stage load/store unit: one outstanding op, waitrequest/readdatavalid bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses with exc_addr_err.
module pipe_lsu_aligned_access
    import pipe_mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    localparam int LANES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [5:0]        op_opcode,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_rt,
    input  logic [4:0]        op_dest,
    output logic              res_valid,
    output logic              res_we,
    output logic [31:0]       res_data,
    output logic [4:0]        res_dest,
    output logic              exc_addr_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LANES-1:0]  mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_readdatavalid
);

    localparam int LANE_W = $clog2(LANES);

    lsu_state_t        state_q, state_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rt_q, rt_d;
    logic [4:0]        dest_q, dest_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [LANES-1:0]  steer_be;
    logic [DATA_W-1:0] steer_wdata;
    logic [31:0]       steer_load;

    pipe_lane_steer #(.DATA_W(DATA_W)) u_steer (
        .opcode     (opcode_q),
        .addr_lo    (addr_q[LANE_W-1:0]),
        .rt         (rt_q),
        .rdata      (rdata_q),
        .byteenable (steer_be),
        .writedata  (steer_wdata),
        .load_data  (steer_load)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            addr_q   <= '0;
            rt_q     <= '0;
            dest_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
            rt_q     <= rt_d;
            dest_q   <= dest_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Handshake: an op transfers on a cycle with op_valid & op_ready; op_ready is
    // high only in IDLE. The memory command transfers on the first CMD cycle with
    // mem_waitrequest low and is held unchanged until then.
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        addr_d         = addr_q;
        rt_d           = rt_q;
        dest_d         = dest_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        op_ready       = 1'b0;
        res_valid      = 1'b0;
        res_we         = 1'b0;
        res_data       = 32'h0;
        res_dest       = 5'h0;
        exc_addr_err   = 1'b0;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = '0;
        mem_writedata  = '0;

        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    opcode_d = op_opcode;
                    addr_d   = op_addr;
                    rt_d     = op_rt;
                    dest_d   = op_dest;
                    err_d    = 1'b0;
                    if (!is_load(op_opcode) && !is_store(op_opcode)) begin
                        state_d = ST_RESP;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (is_misaligned(op_opcode, op_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                    else begin
                        state_d = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                mem_read       = is_load(opcode_q);
                mem_write      = is_store(opcode_q);
                mem_address    = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                mem_byteenable = steer_be;
                mem_writedata  = is_store(opcode_q) ? steer_wdata : '0;
                if (!mem_waitrequest) begin
                    state_d = is_load(opcode_q) ? ST_WAIT_RD : ST_RESP;
                end
            end
            ST_WAIT_RD: begin
                if (mem_readdatavalid) begin
                    rdata_d = mem_readdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                res_valid = 1'b1;
                res_dest  = dest_q;
                res_we    = is_load(opcode_q) && !err_q;
                res_data  = res_we ? steer_load : 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                exc_addr_err = err_q;
`endif
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipe_lsu_aligned_access.sv
// Directed bench for pipe_lsu_aligned_access: 32-bit and 64-bit instances driven
// in lockstep; expectations adapt to LSU_MISALIGN_TRAP_EN.
module tb_pipe_lsu_aligned_access;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LWL = 6'h22, LW = 6'h23,
                           LBU = 6'h24, LHU = 6'h25, LWR = 6'h26,
                           SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    logic        clk;
    logic        reset_n;
    logic        op_valid;
    logic [5:0]  op_opcode;
    logic [31:0] op_addr;
    logic [31:0] op_rt;
    logic [4:0]  op_dest;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [31:0] rd32;
    logic [63:0] rd64;

    logic        op_ready_32, res_valid_32, res_we_32, exc_32, mem_read_32, mem_write_32;
    logic [31:0] res_data_32, mem_address_32, mem_writedata_32;
    logic [4:0]  res_dest_32;
    logic [3:0]  mem_byteenable_32;

    logic        op_ready_64, res_valid_64, res_we_64, exc_64, mem_read_64, mem_write_64;
    logic [31:0] res_data_64, mem_address_64;
    logic [63:0] mem_writedata_64;
    logic [4:0]  res_dest_64;
    logic [7:0]  mem_byteenable_64;

    int n_cmp;
    int n_err;

    logic        obs_ready, obs_rd32, obs_wr32, obs_rd64, obs_wr64;
    logic [31:0] obs_addr32, obs_addr64, obs_wd32;
    logic [63:0] obs_wd64;
    logic [3:0]  obs_be32;
    logic [7:0]  obs_be64;
    logic        obs_rv32, obs_we32, obs_exc32, obs_rv64, obs_we64;
    logic [31:0] obs_res32, obs_res64;
    logic [4:0]  obs_dest32;

    pipe_lsu_aligned_access #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready_32), .op_opcode(op_opcode),
        .op_addr(op_addr), .op_rt(op_rt), .op_dest(op_dest),
        .res_valid(res_valid_32), .res_we(res_we_32), .res_data(res_data_32),
        .res_dest(res_dest_32), .exc_addr_err(exc_32),
        .mem_address(mem_address_32), .mem_read(mem_read_32), .mem_write(mem_write_32),
        .mem_byteenable(mem_byteenable_32), .mem_writedata(mem_writedata_32),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(rd32),
        .mem_readdatavalid(mem_readdatavalid)
    );

    pipe_lsu_aligned_access #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready_64), .op_opcode(op_opcode),
        .op_addr(op_addr), .op_rt(op_rt), .op_dest(op_dest),
        .res_valid(res_valid_64), .res_we(res_we_64), .res_data(res_data_64),
        .res_dest(res_dest_64), .exc_addr_err(exc_64),
        .mem_address(mem_address_64), .mem_read(mem_read_64), .mem_write(mem_write_64),
        .mem_byteenable(mem_byteenable_64), .mem_writedata(mem_writedata_64),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(rd64),
        .mem_readdatavalid(mem_readdatavalid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks: the DUTs are idle on entry and idle again on return
    task automatic do_load(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] d32, input logic [63:0] d64, input logic [4:0] dest);
        op_valid = 1'b1; op_opcode = opc; op_addr = addr; op_rt = rt; op_dest = dest;
        obs_ready = op_ready_32 & op_ready_64;
        tick();
        op_valid = 1'b0;
        obs_rd32 = mem_read_32;  obs_wr32 = mem_write_32;
        obs_rd64 = mem_read_64;  obs_wr64 = mem_write_64;
        obs_addr32 = mem_address_32; obs_addr64 = mem_address_64;
        obs_be32 = mem_byteenable_32; obs_be64 = mem_byteenable_64;
        tick();
        mem_readdatavalid = 1'b1; rd32 = d32; rd64 = d64;
        tick();
        mem_readdatavalid = 1'b0;
        obs_rv32 = res_valid_32; obs_we32 = res_we_32; obs_res32 = res_data_32;
        obs_dest32 = res_dest_32; obs_exc32 = exc_32;
        obs_rv64 = res_valid_64; obs_we64 = res_we_64; obs_res64 = res_data_64;
        tick();
    endtask

    task automatic do_store(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] rt,
                            input logic [4:0] dest);
        op_valid = 1'b1; op_opcode = opc; op_addr = addr; op_rt = rt; op_dest = dest;
        obs_ready = op_ready_32 & op_ready_64;
        tick();
        op_valid = 1'b0;
        obs_rd32 = mem_read_32;  obs_wr32 = mem_write_32;
        obs_rd64 = mem_read_64;  obs_wr64 = mem_write_64;
        obs_addr32 = mem_address_32; obs_addr64 = mem_address_64;
        obs_be32 = mem_byteenable_32; obs_be64 = mem_byteenable_64;
        obs_wd32 = mem_writedata_32; obs_wd64 = mem_writedata_64;
        tick();
        obs_rv32 = res_valid_32; obs_we32 = res_we_32; obs_res32 = res_data_32;
        obs_dest32 = res_dest_32; obs_exc32 = exc_32;
        obs_rv64 = res_valid_64; obs_we64 = res_we_64; obs_res64 = res_data_64;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; op_valid = 1'b0; op_opcode = '0; op_addr = '0; op_rt = '0; op_dest = '0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; rd32 = '0; rd64 = '0;
        tick(); tick();
        n_cmp++;
        if ({op_ready_32, mem_read_32, mem_write_32, res_valid_32, res_we_32, exc_32} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctl32: got %b expected 100000",
                     {op_ready_32, mem_read_32, mem_write_32, res_valid_32, res_we_32, exc_32});
        end
        n_cmp++;
        if ({mem_address_32, mem_byteenable_32, mem_writedata_32, res_data_32, res_dest_32} !== '0) begin
            n_err++;
            $display("FAIL reset_data32: got addr %h be %b wd %h res %h dest %h expected all 0",
                     mem_address_32, mem_byteenable_32, mem_writedata_32, res_data_32, res_dest_32);
        end
        n_cmp++;
        if ({op_ready_64, mem_read_64, mem_write_64, res_valid_64, mem_byteenable_64, mem_writedata_64} !== {1'b1, 75'h0}) begin
            n_err++;
            $display("FAIL reset_64: got ready %b rd %b wr %b rv %b be %h wd %h expected ready 1 rest 0",
                     op_ready_64, mem_read_64, mem_write_64, res_valid_64, mem_byteenable_64, mem_writedata_64);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_lb();
        do_load(LB, 32'h1003, 32'h0, 32'h80112233, {32'h0, 32'h80112233}, 5'd5);
        n_cmp++;
        if ({obs_ready, obs_rd32, obs_wr32, obs_addr32, obs_be32} !== {3'b110, 32'h1000, 4'b1000}) begin
            n_err++;
            $display("FAIL lb_cmd32: got ready %b rd %b wr %b addr %h be %b expected 1 1 0 00001000 1000",
                     obs_ready, obs_rd32, obs_wr32, obs_addr32, obs_be32);
        end
        n_cmp++;
        if ({obs_rv32, obs_we32, obs_res32, obs_dest32} !== {2'b11, 32'hFFFFFF80, 5'd5}) begin
            n_err++;
            $display("FAIL lb_res32: got rv %b we %b data %h dest %0d expected 1 1 ffffff80 5",
                     obs_rv32, obs_we32, obs_res32, obs_dest32);
        end
        n_cmp++;
        if ({obs_addr64, obs_be64, obs_res64} !== {32'h1000, 8'h08, 32'hFFFFFF80}) begin
            n_err++;
            $display("FAIL lb_64: got addr %h be %h data %h expected 00001000 08 ffffff80",
                     obs_addr64, obs_be64, obs_res64);
        end
    endtask

    task automatic test_sh64();
        do_store(SH, 32'h2006, 32'h0000BEEF, 5'd7);
        n_cmp++;
        if ({obs_wr64, obs_rd64, obs_addr64, obs_be64} !== {2'b10, 32'h2000, 8'b1100_0000}) begin
            n_err++;
            $display("FAIL sh_cmd64: got wr %b rd %b addr %h be %b expected 1 0 00002000 11000000",
                     obs_wr64, obs_rd64, obs_addr64, obs_be64);
        end
        n_cmp++;
        if ({obs_wd64[63:56], obs_wd64[55:48]} !== 16'hBEEF || obs_wd64 !== 64'hBEEFBEEFBEEFBEEF) begin
            n_err++;
            $display("FAIL sh_wdata64: got %h expected beefbeefbeefbeef", obs_wd64);
        end
        n_cmp++;
        if ({obs_addr32, obs_be32, obs_wd32} !== {32'h2004, 4'b1100, 32'hBEEFBEEF}) begin
            n_err++;
            $display("FAIL sh_32: got addr %h be %b wd %h expected 00002004 1100 beefbeef",
                     obs_addr32, obs_be32, obs_wd32);
        end
        n_cmp++;
        if ({obs_rv32, obs_we32, obs_exc32, obs_dest32, obs_rv64, obs_we64} !== {3'b100, 5'd7, 2'b10}) begin
            n_err++;
            $display("FAIL sh_res: got rv %b we %b exc %b dest %0d rv64 %b we64 %b expected 1 0 0 7 1 0",
                     obs_rv32, obs_we32, obs_exc32, obs_dest32, obs_rv64, obs_we64);
        end
    endtask

    task automatic test_lwl_lwr();
        do_load(LWL, 32'h11, 32'hAABBCCDD, 32'h44332211, {32'hDEADBEEF, 32'h44332211}, 5'd8);
        n_cmp++;
        if ({obs_be32, obs_be64, obs_res32, obs_res64, obs_we32} !== {4'b0011, 8'h03, 32'h2211CCDD, 32'h2211CCDD, 1'b1}) begin
            n_err++;
            $display("FAIL lwl: got be32 %b be64 %h res32 %h res64 %h we %b expected 0011 03 2211ccdd 2211ccdd 1",
                     obs_be32, obs_be64, obs_res32, obs_res64, obs_we32);
        end
        do_load(LWR, 32'h11, 32'hAABBCCDD, 32'h44332211, {32'hDEADBEEF, 32'h44332211}, 5'd9);
        n_cmp++;
        if ({obs_be32, obs_be64, obs_res32, obs_res64, obs_addr64} !== {4'b1110, 8'h0E, 32'hAA443322, 32'hAA443322, 32'h10}) begin
            n_err++;
            $display("FAIL lwr: got be32 %b be64 %h res32 %h res64 %h addr64 %h expected 1110 0e aa443322 aa443322 00000010",
                     obs_be32, obs_be64, obs_res32, obs_res64, obs_addr64);
        end
    endtask

    task automatic test_subword_loads();
        do_load(LBU, 32'h3002, 32'h0, 32'h00F00000, {32'h0, 32'h00F00000}, 5'd1);
        n_cmp++;
        if ({obs_be32, obs_be64, obs_res32, obs_res64} !== {4'b0100, 8'h04, 32'h000000F0, 32'h000000F0}) begin
            n_err++;
            $display("FAIL lbu: got be32 %b be64 %h res32 %h res64 %h expected 0100 04 000000f0 000000f0",
                     obs_be32, obs_be64, obs_res32, obs_res64);
        end
        do_load(LH, 32'h3002, 32'h0, 32'h80010000, {32'h0, 32'h80010000}, 5'd2);
        n_cmp++;
        if ({obs_be32, obs_be64, obs_res32, obs_res64} !== {4'b1100, 8'h0C, 32'hFFFF8001, 32'hFFFF8001}) begin
            n_err++;
            $display("FAIL lh: got be32 %b be64 %h res32 %h res64 %h expected 1100 0c ffff8001 ffff8001",
                     obs_be32, obs_be64, obs_res32, obs_res64);
        end
        do_load(LHU, 32'h3006, 32'h0, 32'hABCD0000, {32'hABCD0000, 32'h0}, 5'd3);
        n_cmp++;
        if ({obs_be32, obs_be64, obs_res32, obs_res64} !== {4'b1100, 8'hC0, 32'h0000ABCD, 32'h0000ABCD}) begin
            n_err++;
            $display("FAIL lhu: got be32 %b be64 %h res32 %h res64 %h expected 1100 c0 0000abcd 0000abcd",
                     obs_be32, obs_be64, obs_res32, obs_res64);
        end
        do_load(LW, 32'h3004, 32'h0, 32'h11223344, {32'h11223344, 32'h99999999}, 5'd4);
        n_cmp++;
        if ({obs_be32, obs_be64, obs_res32, obs_res64, obs_addr64} !== {4'hF, 8'hF0, 32'h11223344, 32'h11223344, 32'h3000}) begin
            n_err++;
            $display("FAIL lw_upper: got be32 %b be64 %h res32 %h res64 %h addr64 %h expected 1111 f0 11223344 11223344 00003000",
                     obs_be32, obs_be64, obs_res32, obs_res64, obs_addr64);
        end
    endtask

    task automatic test_back_to_back();
        do_store(SW, 32'h3004, 32'hCAFEF00D, 5'd10);
        n_cmp++;
        if ({obs_be32, obs_be64, obs_wd32, obs_wd64, obs_rv32} !== {4'hF, 8'hF0, 32'hCAFEF00D, 64'hCAFEF00DCAFEF00D, 1'b1}) begin
            n_err++;
            $display("FAIL sw: got be32 %b be64 %h wd32 %h wd64 %h rv %b expected 1111 f0 cafef00d cafef00dcafef00d 1",
                     obs_be32, obs_be64, obs_wd32, obs_wd64, obs_rv32);
        end
        do_store(SB, 32'h3001, 32'h0000005A, 5'd11);
        n_cmp++;
        if ({obs_ready, obs_be32, obs_be64, obs_wd32, obs_wd64, obs_rv32, obs_dest32} !==
            {1'b1, 4'b0010, 8'h02, 32'h5A5A5A5A, 64'h5A5A5A5A5A5A5A5A, 1'b1, 5'd11}) begin
            n_err++;
            $display("FAIL sb_b2b: got ready %b be32 %b be64 %h wd32 %h wd64 %h rv %b dest %0d expected 1 0010 02 5a5a5a5a 5a5a5a5a5a5a5a5a 1 11",
                     obs_ready, obs_be32, obs_be64, obs_wd32, obs_wd64, obs_rv32, obs_dest32);
        end
    endtask

    task automatic test_waitrequest();
        logic stable;
        int   rv_count;
        logic [31:0] res_seen;
        stable = 1'b1; rv_count = 0; res_seen = '0;
        mem_waitrequest = 1'b1;
        op_valid = 1'b1; op_opcode = LW; op_addr = 32'h100; op_rt = '0; op_dest = 5'd9;
        tick();
        op_valid = 1'b0;
        // stray read data during the stalled command must be ignored
        mem_readdatavalid = 1'b1; rd32 = 32'hBAD0BAD0; rd64 = 64'hBAD0BAD0BAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            if (!(mem_read_32 === 1'b1 && mem_byteenable_32 === 4'hF && mem_address_32 === 32'h100 &&
                  op_ready_32 === 1'b0 && res_valid_32 === 1'b0)) stable = 1'b0;
            tick();
        end
        mem_readdatavalid = 1'b0;
        n_cmp++;
        if (stable !== 1'b1 || mem_read_32 !== 1'b1) begin
            n_err++;
            $display("FAIL wait_stable: got stable %b mem_read %b expected 1 1", stable, mem_read_32);
        end
        mem_waitrequest = 1'b0;
        tick();
        mem_readdatavalid = 1'b1; rd32 = 32'hA5A51234; rd64 = {32'h0, 32'hA5A51234};
        tick();
        mem_readdatavalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (res_valid_32 === 1'b1) begin
                rv_count++;
                res_seen = res_data_32;
            end
            tick();
        end
        n_cmp++;
        if (rv_count !== 1 || res_seen !== 32'hA5A51234) begin
            n_err++;
            $display("FAIL wait_resp: got pulses %0d data %h expected 1 a5a51234", rv_count, res_seen);
        end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        op_valid = 1'b1; op_opcode = LW; op_addr = 32'h102; op_rt = '0; op_dest = 5'd12;
        tick();
        op_valid = 1'b0;
        n_cmp++;
        if ({mem_read_32, res_valid_32, res_we_32, exc_32, mem_read_64, res_valid_64, exc_64, res_dest_32} !==
            {7'b0101011, 5'd12}) begin
            n_err++;
            $display("FAIL misalign_trap: got rd %b rv %b we %b exc %b rd64 %b rv64 %b exc64 %b dest %0d expected 0 1 0 1 0 1 1 12",
                     mem_read_32, res_valid_32, res_we_32, exc_32, mem_read_64, res_valid_64, exc_64, res_dest_32);
        end
        tick();
        n_cmp++;
        if ({res_valid_32, exc_32, op_ready_32} !== 3'b001) begin
            n_err++;
            $display("FAIL misalign_trap_end: got rv %b exc %b ready %b expected 0 0 1",
                     res_valid_32, exc_32, op_ready_32);
        end
`else
        do_load(LW, 32'h102, 32'h0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd12);
        n_cmp++;
        if ({obs_rd32, obs_rd64, obs_be32, obs_be64} !== {2'b11, 4'h0, 8'h00}) begin
            n_err++;
            $display("FAIL misalign_cmd: got rd32 %b rd64 %b be32 %b be64 %h expected 1 1 0000 00",
                     obs_rd32, obs_rd64, obs_be32, obs_be64);
        end
        n_cmp++;
        if ({obs_rv32, obs_we32, obs_exc32, obs_res32, obs_res64} !== {3'b110, 64'h0}) begin
            n_err++;
            $display("FAIL misalign_res: got rv %b we %b exc %b res32 %h res64 %h expected 1 1 0 0 0",
                     obs_rv32, obs_we32, obs_exc32, obs_res32, obs_res64);
        end
`endif
    endtask

    task automatic test_unsupported();
        op_valid = 1'b1; op_opcode = 6'h0F; op_addr = 32'h40; op_rt = '0; op_dest = 5'd3;
        tick();
        op_valid = 1'b0;
        n_cmp++;
        if ({mem_read_32, mem_write_32, res_valid_32, res_we_32, op_ready_32, exc_32, res_dest_32} !== {6'b001000, 5'd3}) begin
            n_err++;
            $display("FAIL unsupported: got rd %b wr %b rv %b we %b ready %b exc %b dest %0d expected 0 0 1 0 0 0 3",
                     mem_read_32, mem_write_32, res_valid_32, res_we_32, op_ready_32, exc_32, res_dest_32);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op_opcode = LW; op_addr = 32'h200; op_rt = '0; op_dest = 5'd14;
        tick();
        op_valid = 1'b0;
        tick();
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({op_ready_32, mem_read_32, res_valid_32, op_ready_64, mem_read_64, res_valid_64} !== 6'b100100) begin
            n_err++;
            $display("FAIL reset_mid: got %b expected 100100",
                     {op_ready_32, mem_read_32, res_valid_32, op_ready_64, mem_read_64, res_valid_64});
        end
        tick(); tick();
        reset_n = 1'b1;
        mem_readdatavalid = 1'b1; rd32 = 32'hDEADDEAD; rd64 = 64'hDEADDEADDEADDEAD;
        tick();
        mem_readdatavalid = 1'b0;
        n_cmp++;
        if ({res_valid_32, op_ready_32, res_valid_64} !== 3'b010) begin
            n_err++;
            $display("FAIL reset_stray_rdv: got rv %b ready %b rv64 %b expected 0 1 0",
                     res_valid_32, op_ready_32, res_valid_64);
        end
        do_load(LW, 32'h300, 32'h0, 32'h12345678, {32'h0, 32'h12345678}, 5'd15);
        n_cmp++;
        if ({obs_rv32, obs_we32, obs_res32, obs_dest32, obs_res64} !== {2'b11, 32'h12345678, 5'd15, 32'h12345678}) begin
            n_err++;
            $display("FAIL reset_recover: got rv %b we %b res %h dest %0d res64 %h expected 1 1 12345678 15 12345678",
                     obs_rv32, obs_we32, obs_res32, obs_dest32, obs_res64);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_lb();
        test_sh64();
        test_lwl_lwr();
        test_subword_loads();
        test_back_to_back();
        test_waitrequest();
        test_misalign();
        test_unsupported();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
